// File: rtl/conv_kxk_stream_unit_if.sv
// Signal bundle for conv_kxk_stream_unit: weight load port, pixel stream in, result stream out.
interface conv_kxk_stream_unit_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] riscv_data;
    logic                  wm_load;
    logic                  wm_clear;
    logic                  wm_loaded;
    logic                  pix_valid;
    logic                  pix_ready;
    logic [DATA_WIDTH-1:0] pix_data;
    logic [DATA_WIDTH-1:0] psum_in;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  frame_done;

    modport master (
        output riscv_data, wm_load, wm_clear, pix_valid, pix_data, psum_in,
        input  wm_loaded, pix_ready, out_valid, out_data, frame_done
    );

    modport slave (
        input  riscv_data, wm_load, wm_clear, pix_valid, pix_data, psum_in,
        output wm_loaded, pix_ready, out_valid, out_data, frame_done
    );
endinterface

// File: rtl/conv_kxk_stream_unit.sv
// Streaming KxK fixed-point convolution: serial weight load, raster IFM stream, pipelined MAC tree.
// Optional macro CONV_RELU_EN clamps negative results to zero.
module conv_kxk_stream_unit #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned FRAC_BITS   = 16,
    parameter int unsigned IFM_SIZE    = 32,
    parameter int unsigned KERNAL_SIZE = 5
) (
    input logic                  clk,
    input logic                  reset,
    conv_kxk_stream_unit_if.slave bus
);
    localparam int unsigned DW       = DATA_WIDTH;
    localparam int unsigned K        = KERNAL_SIZE;
    localparam int unsigned NTAPS    = K * K;
    localparam int unsigned LVLS     = $clog2(NTAPS);
    localparam int unsigned NP       = 1 << LVLS;
    localparam int unsigned PIPE_LAT = 2 + LVLS;
    localparam int unsigned SW       = DW + LVLS + 1;
    localparam int unsigned PW       = 2 * DW;
    localparam int unsigned LB_DEPTH = (K - 1) * IFM_SIZE + K;
    localparam int unsigned WCW      = $clog2(NTAPS);
    localparam int unsigned RCW      = (IFM_SIZE > 1) ? $clog2(IFM_SIZE) : 1;

    localparam logic signed [SW-1:0] SAT_MAX = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN = {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [0:0] {S_LOAD, S_RUN} state_t;

    state_t                 state_q, state_d;
    logic [WCW-1:0]         wcnt_q, wcnt_d;
    logic [RCW-1:0]         row_q, row_d;
    logic [RCW-1:0]         col_q, col_d;
    logic                   run_q, run_d;
    logic                   wr_en_c;
    logic                   accept_c;
    logic                   win_c;
    logic                   last_c;

    logic [DW-1:0]          weight_q [NTAPS];
    logic [DW-1:0]          lb_q     [LB_DEPTH];
    logic signed [SW-1:0]   leaf_c   [NP];
    logic signed [SW-1:0]   tree_q   [2*NP-1];
    logic [PIPE_LAT-1:0]    vld_q;
    logic [PIPE_LAT-1:0]    last_q;
    logic [DW-1:0]          psum_q   [PIPE_LAT];
    logic signed [SW-1:0]   sum_c;
    logic [DW-1:0]          res_c;
    logic                   out_valid_q;
    logic                   frame_done_q;
    logic [DW-1:0]          out_data_q;

    // Line-buffer position of tap t; index 0 is the newest pixel, i.e. window (K-1,K-1).
    function automatic int unsigned tap_idx(input int unsigned t);
        return (K - 1 - t / K) * IFM_SIZE + (K - 1 - t % K);
    endfunction

    // (w*x)>>>FRAC_BITS on the full product, clamped to the word range so the tree cannot wrap.
    function automatic logic signed [SW-1:0] scaled_product(input logic [DW-1:0] w,
                                                            input logic [DW-1:0] x);
        logic signed [PW-1:0] wx;
        logic signed [PW-1:0] xx;
        logic signed [PW-1:0] pm;
        logic signed [PW-1:0] ps;
        wx = PW'($signed(w));
        xx = PW'($signed(x));
        pm = wx * xx;
        ps = pm >>> FRAC_BITS;
        if ((&ps[PW-1:DW-1]) || (~|ps[PW-1:DW-1])) begin
            return SW'($signed(ps[DW-1:0]));
        end
        return ps[PW-1] ? SAT_MIN : SAT_MAX;
    endfunction

    // Control: weight-load / run FSM plus raster position counters.
    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        row_d    = row_q;
        col_d    = col_q;
        wr_en_c  = 1'b0;
        accept_c = bus.pix_valid & run_q & ~bus.wm_clear;
        win_c    = accept_c && (row_q >= RCW'(K - 1)) && (col_q >= RCW'(K - 1));
        last_c   = (row_q == RCW'(IFM_SIZE - 1)) && (col_q == RCW'(IFM_SIZE - 1));

        if (bus.wm_clear) begin
            state_d = S_LOAD;
            wcnt_d  = '0;
            row_d   = '0;
            col_d   = '0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (bus.wm_load) begin
                        wr_en_c = 1'b1;
                        if (wcnt_q == WCW'(NTAPS - 1)) begin
                            state_d = S_RUN;
                            wcnt_d  = '0;
                        end else begin
                            wcnt_d = wcnt_q + WCW'(1);
                        end
                    end
                end
                S_RUN:   state_d = S_RUN;
                default: state_d = S_LOAD;
            endcase

            if (accept_c) begin
                if (col_q == RCW'(IFM_SIZE - 1)) begin
                    col_d = '0;
                    row_d = (row_q == RCW'(IFM_SIZE - 1)) ? '0 : row_q + RCW'(1);
                end else begin
                    col_d = col_q + RCW'(1);
                end
            end
        end
        run_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_LOAD;
            wcnt_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            row_q   <= row_d;
            col_q   <= col_d;
            run_q   <= run_d;
        end
    end

    // Weight store and pixel line buffer; both are wiped by wm_clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int t = 0; t < NTAPS; t++) weight_q[t] <= '0;
            for (int i = 0; i < LB_DEPTH; i++) lb_q[i] <= '0;
        end else if (bus.wm_clear) begin
            for (int t = 0; t < NTAPS; t++) weight_q[t] <= '0;
            for (int i = 0; i < LB_DEPTH; i++) lb_q[i] <= '0;
        end else begin
            if (wr_en_c) weight_q[wcnt_q] <= bus.riscv_data;
            if (accept_c) begin
                lb_q[0] <= bus.pix_data;
                for (int i = 1; i < LB_DEPTH; i++) lb_q[i] <= lb_q[i-1];
            end
        end
    end

    always_comb begin
        for (int t = 0; t < NP; t++) leaf_c[t] = '0;
        for (int t = 0; t < NTAPS; t++) leaf_c[t] = scaled_product(weight_q[t], lb_q[tap_idx(t)]);
    end

    // Heap-ordered adder tree: leaves are the product stage, node 0 is the full sum.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int n = 0; n < 2*NP-1; n++) tree_q[n] <= '0;
        end else begin
            for (int n = 0; n < NP-1; n++) tree_q[n] <= tree_q[2*n+1] + tree_q[2*n+2];
            for (int t = 0; t < NP; t++) tree_q[NP-1+t] <= leaf_c[t];
        end
    end

    // Token side-band travels alongside the tree and is never stalled, even through wm_clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q  <= '0;
            last_q <= '0;
            for (int s = 0; s < PIPE_LAT; s++) psum_q[s] <= '0;
        end else begin
            vld_q     <= {vld_q[PIPE_LAT-2:0], win_c};
            last_q    <= {last_q[PIPE_LAT-2:0], last_c};
            psum_q[0] <= bus.psum_in;
            for (int s = 1; s < PIPE_LAT; s++) psum_q[s] <= psum_q[s-1];
        end
    end

    always_comb begin
        sum_c = tree_q[0] + SW'($signed(psum_q[PIPE_LAT-1]));
        res_c = sum_c[DW-1:0];
        if (sum_c > SAT_MAX) begin
            res_c = {1'b0, {(DW-1){1'b1}}};
        end else if (sum_c < SAT_MIN) begin
            res_c = {1'b1, {(DW-1){1'b0}}};
        end
`ifdef CONV_RELU_EN
        if (res_c[DW-1]) res_c = '0;
`else
        res_c = res_c;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            out_data_q   <= '0;
        end else begin
            out_valid_q  <= vld_q[PIPE_LAT-1];
            frame_done_q <= vld_q[PIPE_LAT-1] & last_q[PIPE_LAT-1];
            if (vld_q[PIPE_LAT-1]) out_data_q <= res_c;
        end
    end

    assign bus.wm_loaded  = run_q;
    assign bus.pix_ready  = run_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_kxk_stream_unit.sv
// Self-checking bench for conv_kxk_stream_unit (K=3, IFM=4, FRAC=16): vector table plus
// reset / wm_clear sequences, with a timed scoreboard of expected results.
module tb_conv_kxk_stream_unit;
    localparam int DW  = 32;
    localparam int FB  = 16;
    localparam int IFM = 4;
    localparam int K   = 3;
    localparam int NW  = IFM - K + 1;
    localparam int LAT = 6;
    localparam int NV  = 10;

    typedef struct packed {
        logic [8:0][31:0] w;
        logic [31:0]      psum;
        logic             pc;
        logic [31:0]      pixc;
        logic [4:0]       sh;
        logic             gaps;
        logic [1:0]       frames;
        logic [3:0][31:0] res;
    } vec_t;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic [31:0] due;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   ecnt = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   pos;
    logic mon_en;
    logic [31:0] hold;
    exp_t sb_q[$];
    vec_t tbl [NV];

    always #5 clk = ~clk;
    always @(posedge clk) ecnt <= ecnt + 1;

    conv_kxk_stream_unit_if #(.DATA_WIDTH(DW)) bus ();

    conv_kxk_stream_unit #(
        .DATA_WIDTH (DW),
        .FRAC_BITS  (FB),
        .IFM_SIZE   (IFM),
        .KERNAL_SIZE(K)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (edge %0d)", nm, act, req, ecnt);
        end
    endfunction

    function automatic logic [31:0] relu(input logic [31:0] x);
`ifdef CONV_RELU_EN
        return x[31] ? 32'h0 : x;
`else
        return x;
`endif
    endfunction

    function automatic vec_t mk(input logic [31:0] w, input logic [31:0] ps, input logic pc,
                                input logic [31:0] pixc, input logic [4:0] sh, input logic gaps,
                                input int frames, input logic [31:0] e0, input logic [31:0] e1,
                                input logic [31:0] e2, input logic [31:0] e3);
        vec_t v;
        v.w      = {9{w}};
        v.psum   = ps;
        v.pc     = pc;
        v.pixc   = pixc;
        v.sh     = sh;
        v.gaps   = gaps;
        v.frames = 2'(frames);
        v.res[0] = relu(e0);
        v.res[1] = relu(e1);
        v.res[2] = relu(e2);
        v.res[3] = relu(e3);
        return v;
    endfunction

    function automatic logic [31:0] pix_of(input vec_t v, input int k);
        logic [31:0] base;
        base = 32'(k + 1);
        return v.pc ? v.pixc : (base << v.sh);
    endfunction

    function automatic logic [63:0] outs();
        return 64'({bus.out_valid, bus.frame_done, bus.wm_loaded, bus.pix_ready, bus.out_data});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic monitor_loop();
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                while (sb_q.size() != 0 && int'(sb_q[0].due) < ecnt) begin
                    e = sb_q.pop_front();
                    chk("missing_out_due_edge", 64'(ecnt), 64'(e.due));
                end
                if (bus.out_valid) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_out_valid", 64'(bus.out_data), 64'hDEAD);
                    end else begin
                        e = sb_q.pop_front();
                        chk("out_data", 64'(bus.out_data), 64'(e.data));
                        chk("out_edge_frame_done", {31'(ecnt), bus.frame_done}, {e.due[30:0], e.last});
                        hold = e.data;
                    end
                end else begin
                    chk("idle_hold", {bus.frame_done, bus.out_data}, {1'b0, hold});
                end
            end
        end
    endtask

    task automatic load_weights(input logic [8:0][31:0] w);
        for (int t = 0; t < 9; t++) begin
            bus.riscv_data = w[t];
            bus.wm_load    = 1'b1;
            tick();
        end
        bus.wm_load = 1'b0;
    endtask

    task automatic clear_unit();
        bus.wm_clear = 1'b1;
        tick();
        bus.wm_clear = 1'b0;
        pos = 0;
    endtask

    // Model: the bench tracks the raster position itself and schedules each window result.
    task automatic drive_pix(input vec_t v, input int k);
        exp_t e;
        int r, c;
        bus.pix_valid = 1'b1;
        bus.pix_data  = pix_of(v, k);
        bus.psum_in   = v.psum;
        tick();
        bus.pix_valid = 1'b0;
        r = pos / IFM;
        c = pos % IFM;
        if (r >= K - 1 && c >= K - 1) begin
            e.data = v.res[(r - (K - 1)) * NW + (c - (K - 1))];
            e.last = (pos == IFM * IFM - 1);
            e.due  = 32'(ecnt + LAT);
            sb_q.push_back(e);
        end
        pos = (pos + 1) % (IFM * IFM);
    endtask

    task automatic run_frame(input vec_t v);
        for (int k = 0; k < IFM * IFM; k++) begin
            if (v.gaps) repeat ($urandom_range(0, 2)) tick();
            drive_pix(v, k);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        chk("drain_queue_empty", 64'(sb_q.size()), 64'd0);
        sb_q.delete();
    endtask

    task automatic probe_not_ready();
        for (int i = 0; i < 3; i++) begin
            bus.pix_valid = 1'b1;
            bus.pix_data  = 32'hFFFF_0000;
            tick();
            chk("pix_ready_while_unloaded", 64'(bus.pix_ready), 64'd0);
        end
        bus.pix_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        mon_en = 1'b0;
        pos = 0;
        hold = '0;
        bus.riscv_data = '0;
        bus.wm_load    = 1'b0;
        bus.wm_clear   = 1'b0;
        bus.pix_valid  = 1'b0;
        bus.pix_data   = '0;
        bus.psum_in    = '0;

        tbl[0] = mk(32'h0001_0000, 32'h0, 1'b0, 32'h0, 5'd16, 1'b0, 1,
                    32'h0036_0000, 32'h003F_0000, 32'h005A_0000, 32'h0063_0000);
        tbl[1] = mk(32'h0001_0000, 32'h0005_0000, 1'b0, 32'h0, 5'd16, 1'b0, 2,
                    32'h003B_0000, 32'h0044_0000, 32'h005F_0000, 32'h0068_0000);
        tbl[2] = mk(32'h0, 32'h0, 1'b0, 32'h0, 5'd16, 1'b0, 1,
                    32'h0001_0000, 32'h0002_0000, 32'h0005_0000, 32'h0006_0000);
        tbl[2].w[0] = 32'h0001_0000;
        tbl[3] = mk(32'h0, 32'h0, 1'b0, 32'h0, 5'd16, 1'b0, 1,
                    32'h0003_0000, 32'h0004_0000, 32'h0007_0000, 32'h0008_0000);
        tbl[3].w[2] = 32'h0001_0000;
        tbl[4] = mk(32'h0, 32'h0, 1'b0, 32'h0, 5'd16, 1'b0, 1,
                    32'h000B_0000, 32'h000C_0000, 32'h000F_0000, 32'h0010_0000);
        tbl[4].w[8] = 32'h0001_0000;
        tbl[5] = mk(32'h0000_8000, 32'h0, 1'b0, 32'h0, 5'd16, 1'b0, 1,
                    32'h001B_0000, 32'h001F_8000, 32'h002D_0000, 32'h0031_8000);
        tbl[6] = mk(32'hFFFF_FFFF, 32'h0, 1'b0, 32'h0, 5'd0, 1'b0, 1,
                    32'hFFFF_FFF7, 32'hFFFF_FFF7, 32'hFFFF_FFF7, 32'hFFFF_FFF7);
        tbl[7] = mk(32'h7FFF_0000, 32'h0, 1'b1, 32'h7FFF_0000, 5'd0, 1'b0, 1,
                    32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        tbl[8] = mk(32'h8001_0000, 32'h0, 1'b1, 32'h7FFF_0000, 5'd0, 1'b0, 1,
                    32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
        tbl[9] = mk(32'h0001_0000, 32'h0, 1'b0, 32'h0, 5'd16, 1'b1, 1,
                    32'h0036_0000, 32'h003F_0000, 32'h005A_0000, 32'h0063_0000);

        fork
            monitor_loop();
        join_none

        repeat (3) tick();
        chk("reset_outputs", outs(), 64'd0);
        reset = 1'b0;
        mon_en = 1'b1;
        tick();

        // Pixels before any weight load are dropped; then one basic frame.
        probe_not_ready();
        load_weights(tbl[0].w);
        chk("wm_loaded_after_load", 64'(bus.wm_loaded), 64'd1);
        run_frame(tbl[0]);
        drain();

        // Asynchronous reset in the middle of a frame with tokens in flight.
        for (int k = 0; k < 11; k++) drive_pix(tbl[0], k);
        #2 reset = 1'b1;
        #1 chk("async_reset_outputs", outs(), 64'd0);
        mon_en = 1'b0;
        sb_q.delete();
        pos = 0;
        hold = '0;
        tick();
        tick();
        reset = 1'b0;
        mon_en = 1'b1;
        probe_not_ready();
        load_weights(tbl[0].w);
        run_frame(tbl[0]);
        drain();

        // wm_clear mid-frame: in-flight windows still emerge; coincident load/pixel lose.
        clear_unit();
        load_weights(tbl[0].w);
        bus.wm_load    = 1'b1;
        bus.riscv_data = 32'hDEAD_BEEF;
        tick();
        bus.wm_load = 1'b0;
        for (int k = 0; k < 12; k++) drive_pix(tbl[0], k);
        bus.wm_clear   = 1'b1;
        bus.wm_load    = 1'b1;
        bus.pix_valid  = 1'b1;
        bus.riscv_data = 32'h0BAD_0000;
        tick();
        bus.wm_clear  = 1'b0;
        bus.wm_load   = 1'b0;
        bus.pix_valid = 1'b0;
        pos = 0;
        chk("loaded_ready_after_clear", {62'd0, bus.wm_loaded, bus.pix_ready}, 64'd0);
        drain();
        load_weights(tbl[0].w);
        run_frame(tbl[0]);
        drain();

        for (int i = 0; i < NV; i++) begin
            clear_unit();
            load_weights(tbl[i].w);
            for (int f = 0; f < int'(tbl[i].frames); f++) run_frame(tbl[i]);
            drain();
        end

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
